// File: rtl/uart_rx_param.sv
// UART receiver: two-flop input synchronizer, 3-sample majority vote per bit, and
// configurable data width, parity mode and stop-bit count. Results are registered on done_tick.
module uart_rx_param #(
  parameter int unsigned FREQ      = 24_000_000,
  parameter int unsigned BAUD_RATE = 9600,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 DATA_serial,
  output logic [DATA_BITS-1:0] DATA_word,
  output logic                 done_tick,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned BitTicks = FREQ / BAUD_RATE;
  localparam int unsigned Half     = BitTicks / 2;
  localparam int unsigned CntW     = $clog2(BitTicks);
  localparam int unsigned IdxW     = $clog2(DATA_BITS);

  localparam logic [CntW-1:0] TickS0   = CntW'(Half - 1);
  localparam logic [CntW-1:0] TickS1   = CntW'(Half);
  localparam logic [CntW-1:0] TickDec  = CntW'(Half + 1);
  localparam logic [CntW-1:0] TickLast = CntW'(BitTicks - 1);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(DATA_BITS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StPar, StStop, StDone} state_e;

  state_e               state;
  logic                 sync1, rx_s;
  logic [CntW-1:0]      cnt;
  logic [IdxW-1:0]      bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 samp0, samp1;
  logic                 par_err_q, frm_err_q;
  logic                 stop_idx;
  logic                 armed;

  logic maj, par_exp, stop_final;

  assign maj        = (samp0 & samp1) | (samp0 & rx_s) | (samp1 & rx_s);
  assign par_exp    = (PARITY == 2) ? (^shreg) : ~(^shreg);
  assign stop_final = (STOP_BITS == 1) || stop_idx;
  assign busy       = (state != StIdle);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= StIdle;
      sync1      <= 1'b1;
      rx_s       <= 1'b1;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      samp0      <= 1'b1;
      samp1      <= 1'b1;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      stop_idx   <= 1'b0;
      armed      <= 1'b1;
      DATA_word  <= '0;
      done_tick  <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sync1     <= DATA_serial;
      rx_s      <= sync1;
      done_tick <= 1'b0;
      if (rx_s) armed <= 1'b1;

      if (state != StIdle && state != StDone) begin
        cnt <= (cnt == TickLast) ? '0 : cnt + CntW'(1);
        if (cnt == TickS0) samp0 <= rx_s;
        if (cnt == TickS1) samp1 <= rx_s;
      end

      case (state)
        StIdle: begin
          cnt <= '0;
          // This cycle is tick 0 of the start bit.
          if (!rx_s && armed) begin
            state     <= StStart;
            cnt       <= CntW'(1);
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
          end
        end
        StStart: begin
          if (cnt == TickDec && maj) begin
            state <= StIdle;
            cnt   <= '0;
          end else if (cnt == TickLast) begin
            state <= StData;
          end
        end
        StData: begin
          if (cnt == TickDec) shreg <= {maj, shreg[DATA_BITS-1:1]};
          if (cnt == TickLast) begin
            if (bit_idx == IdxLast) begin
              bit_idx <= '0;
              state   <= (PARITY != 0) ? StPar : StStop;
            end else begin
              bit_idx <= bit_idx + IdxW'(1);
            end
          end
        end
        StPar: begin
          if (cnt == TickDec && maj != par_exp) par_err_q <= 1'b1;
          if (cnt == TickLast) state <= StStop;
        end
        StStop: begin
          if (cnt == TickDec) begin
            if (!maj) frm_err_q <= 1'b1;
            // Final stop bit ends early so a following start edge is not missed.
            if (stop_final) begin
              state      <= StDone;
              cnt        <= '0;
              done_tick  <= 1'b1;
              DATA_word  <= shreg;
              parity_err <= (PARITY != 0) && par_err_q;
              frame_err  <= frm_err_q | ~maj;
              // A low stop bit may be a break: wait for the line to go high first.
              if (!maj) armed <= 1'b0;
            end
          end else if (cnt == TickLast) begin
            stop_idx <= 1'b1;
          end
        end
        StDone: begin
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three configurations driven with directed frames, checked every
// cycle against a frame-level model of expected words, flags and done_tick timing.
module tb_uart_rx_param;

  localparam int unsigned Freq = 1_600_000;
  localparam int unsigned Baud = 100_000;
  localparam int Bt = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] line = 3'b111;

  logic [7:0] w_a, w_b;
  logic [6:0] w_c;
  logic [2:0] done_v, perr_v, ferr_v, busy_v;
  logic [8:0] word_v [3];

  uart_rx_param #(.FREQ(Freq), .BAUD_RATE(Baud), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
  u_a (.clk(clk), .reset_n(reset_n), .DATA_serial(line[0]), .DATA_word(w_a),
       .done_tick(done_v[0]), .parity_err(perr_v[0]), .frame_err(ferr_v[0]), .busy(busy_v[0]));

  uart_rx_param #(.FREQ(Freq), .BAUD_RATE(Baud), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1))
  u_b (.clk(clk), .reset_n(reset_n), .DATA_serial(line[1]), .DATA_word(w_b),
       .done_tick(done_v[1]), .parity_err(perr_v[1]), .frame_err(ferr_v[1]), .busy(busy_v[1]));

  uart_rx_param #(.FREQ(Freq), .BAUD_RATE(Baud), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2))
  u_c (.clk(clk), .reset_n(reset_n), .DATA_serial(line[2]), .DATA_word(w_c),
       .done_tick(done_v[2]), .parity_err(perr_v[2]), .frame_err(ferr_v[2]), .busy(busy_v[2]));

  assign word_v[0] = {1'b0, w_a};
  assign word_v[1] = {1'b0, w_b};
  assign word_v[2] = {2'b00, w_c};

  always #5 clk = ~clk;

  typedef struct {
    int         inst;
    logic [8:0] word;
    logic       perr;
    logic       ferr;
    int         t0;
    int         lat_c;
  } exp_t;

  exp_t       q[$];
  int         cyc = 0;
  logic       rst_s = 1'b0;
  logic       checking = 1'b0;
  logic [8:0] last_w [3];
  logic       last_p [3];
  logic       last_f [3];
  int         last_lat [3];
  int         checks = 0;
  int         failures = 0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_s <= reset_n;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic int nb_of(input int s);
    return (s == 2) ? 7 : 8;
  endfunction

  function automatic int pm_of(input int s);
    return (s == 1) ? 2 : ((s == 2) ? 1 : 0);
  endfunction

  function automatic int sb_of(input int s);
    return (s == 2) ? 2 : 1;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // par_bit < 0 sends the correct parity bit; rst_bit >= 0 pulses reset inside that line bit.
  task automatic send_frame(input int s, input logic [8:0] data, input int par_bit,
                            input logic stop_lvl, input int hold_low, input int rst_bit);
    logic       bits [16];
    logic [8:0] dm;
    logic       good, pb;
    int         n, nb, pm;
    exp_t       e;
    nb = nb_of(s);
    pm = pm_of(s);
    dm = data & 9'((1 << nb) - 1);
    good = (pm == 2) ? (^dm) : ~(^dm);
    pb = (par_bit < 0) ? good : par_bit[0];
    n = 0;
    bits[n] = 1'b0;
    n = n + 1;
    for (int i = 0; i < nb; i++) begin
      bits[n] = dm[i];
      n = n + 1;
    end
    if (pm != 0) begin
      bits[n] = pb;
      n = n + 1;
    end
    for (int i = 0; i < sb_of(s); i++) begin
      bits[n] = stop_lvl;
      n = n + 1;
    end
    e.inst  = s;
    e.word  = dm;
    e.perr  = (pm != 0) && (pb != good);
    e.ferr  = !stop_lvl;
    e.t0    = cyc;
    e.lat_c = (n - 1) * Bt + 11;
    if (rst_bit < 0) q.push_back(e);
    for (int b = 0; b < n; b++) begin
      line[s] = bits[b];
      for (int t = 0; t < Bt; t++) begin
        if (b == rst_bit && t == 8) reset_n = 1'b0;
        if (b == rst_bit && t == 10) reset_n = 1'b1;
        @(posedge clk);
        #1;
      end
    end
    if (!stop_lvl) idle(hold_low);
    line[s] = 1'b1;
  endtask

  // Frame-level model compare: every cycle each instance's outputs must equal the last
  // delivered expectation, and done_tick must match a queued frame within its latency window.
  always @(negedge clk) begin
    if (checking) begin
      for (int i = 0; i < 3; i++) begin
        if (!rst_s) begin
          last_w[i] = '0;
          last_p[i] = 1'b0;
          last_f[i] = 1'b0;
          chk("done_in_reset", {31'b0, done_v[i]}, 32'd0);
        end else if (done_v[i]) begin
          int j;
          int lat;
          j = -1;
          for (int k = 0; k < q.size(); k++) if (j < 0 && q[k].inst == i) j = k;
          chk("done_expected", {31'b0, (j >= 0)}, 32'd1);
          if (j >= 0) begin
            lat = cyc - q[j].t0;
            last_lat[i] = lat;
            checks++;
            if (lat < q[j].lat_c - 1 || lat > q[j].lat_c + 1) begin
              failures++;
              $display("FAIL latency inst %0d: got %0d cycles required %0d +/-1", i, lat,
                       q[j].lat_c);
            end
            last_w[i] = q[j].word;
            last_p[i] = q[j].perr;
            last_f[i] = q[j].ferr;
            q.delete(j);
          end
        end
        chk("word", {23'b0, word_v[i]}, {23'b0, last_w[i]});
        chk("parity_err", {31'b0, perr_v[i]}, {31'b0, last_p[i]});
        chk("frame_err", {31'b0, ferr_v[i]}, {31'b0, last_f[i]});
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      last_w[i] = '0;
      last_p[i] = 1'b0;
      last_f[i] = 1'b0;
      last_lat[i] = 0;
    end
    idle(4);
    reset_n = 1'b1;
    idle(3);
    checking = 1'b1;
    chk("reset_busy", {29'b0, busy_v}, 32'd0);
    chk("reset_word_a", {24'b0, w_a}, 32'h0);
    chk("reset_done", {29'b0, done_v}, 32'd0);

    // 8N1 0x55
    send_frame(0, 9'h055, -1, 1'b1, 0, -1);
    idle(4);
    chk("a55_word", {24'b0, w_a}, 32'h55);
    chk("a55_flags", {30'b0, perr_v[0], ferr_v[0]}, 32'd0);
    chk("a55_latency_in_window", {31'b0, (last_lat[0] >= 154 && last_lat[0] <= 156)}, 32'd1);

    // Even parity 0xA3: wrong parity bit, then correct
    send_frame(1, 9'h0A3, 1, 1'b1, 0, -1);
    idle(4);
    chk("a3_bad_perr", {31'b0, perr_v[1]}, 32'd1);
    send_frame(1, 9'h0A3, 0, 1'b1, 0, -1);
    idle(4);
    chk("a3_good_perr", {31'b0, perr_v[1]}, 32'd0);
    chk("a3_word", {24'b0, w_b}, 32'hA3);

    // Stop bit low
    send_frame(0, 9'h03C, -1, 1'b0, 0, -1);
    idle(4);
    chk("3c_word", {24'b0, w_a}, 32'h3C);
    chk("3c_ferr", {31'b0, ferr_v[0]}, 32'd1);

    // Start glitch of 4 cycles
    line[0] = 1'b0;
    idle(4);
    line[0] = 1'b1;
    idle(1);
    chk("glitch_busy_hi", {31'b0, busy_v[0]}, 32'd1);
    idle(8);
    chk("glitch_busy_lo", {31'b0, busy_v[0]}, 32'd0);
    idle(40);
    chk("glitch_word_held", {24'b0, w_a}, 32'h3C);
    chk("glitch_ferr_held", {31'b0, ferr_v[0]}, 32'd1);

    // Back-to-back frames
    send_frame(0, 9'h001, -1, 1'b1, 0, -1);
    send_frame(0, 9'h0FE, -1, 1'b1, 0, -1);
    idle(4);
    chk("b2b_word", {24'b0, w_a}, 32'hFE);
    chk("b2b_ferr", {31'b0, ferr_v[0]}, 32'd0);

    // 7O2: correct parity, then wrong parity bit
    send_frame(2, 9'h05A, -1, 1'b1, 0, -1);
    idle(4);
    chk("c5a_word", {25'b0, w_c}, 32'h5A);
    chk("c5a_perr", {31'b0, perr_v[2]}, 32'd0);
    send_frame(2, 9'h05A, 0, 1'b1, 0, -1);
    idle(4);
    chk("c5a_bad_perr", {31'b0, perr_v[2]}, 32'd1);

    // Break: line held low well past one frame
    send_frame(0, 9'h000, -1, 1'b0, 100, -1);
    idle(20);
    chk("break_word", {24'b0, w_a}, 32'h0);
    chk("break_ferr", {31'b0, ferr_v[0]}, 32'd1);

    // Reset during data bit 4, then a clean frame
    send_frame(0, 9'h0F5, -1, 1'b1, 0, 5);
    idle(20);
    chk("rst_word_b", {24'b0, w_b}, 32'h0);
    chk("rst_perr_c", {31'b0, perr_v[2]}, 32'd0);
    send_frame(0, 9'h07E, -1, 1'b1, 0, -1);
    idle(4);
    chk("7e_word", {24'b0, w_a}, 32'h7E);
    chk("7e_ferr", {31'b0, ferr_v[0]}, 32'd0);

    idle(50);
    chk("all_frames_delivered", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
